// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared bitwise logic unit for two requesters
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [15:0]      busy_cnt0,
    output logic [15:0]      busy_cnt1
);

    logic             full_q, full_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      cnt0_q, cnt0_d;
    logic [15:0]      cnt1_q, cnt1_d;

    logic             slot_free;
    logic             gnt_valid;
    logic             gnt_id;
    logic             xfer;
    logic             consume;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, result;

    assign slot_free = !full_q || rsp_ready;
    assign gnt_valid = req0_valid || req1_valid;
    // Under contention the requester not served last wins; otherwise the lone valid one.
    assign gnt_id    = (req0_valid && req1_valid) ? !last_q : req1_valid;
    assign xfer      = gnt_valid && slot_free;
    assign consume   = full_q && rsp_ready;

    assign req0_ready = rst_n && slot_free && gnt_valid && !gnt_id;
    assign req1_ready = rst_n && slot_free && gnt_valid && gnt_id;

    assign sel_op = gnt_id ? req1_op : req0_op;
    assign sel_a  = gnt_id ? req1_a  : req0_a;
    assign sel_b  = gnt_id ? req1_b  : req0_b;

    always_comb begin
        result = '0;
        case (sel_op)
            2'b00:   result = sel_a & sel_b;
            2'b01:   result = sel_a | sel_b;
            2'b10:   result = sel_a ^ sel_b;
            default: result = ~(sel_a | sel_b);
        endcase
    end

    always_comb begin
        full_d = full_q;
        last_d = last_q;
        id_d   = id_q;
        data_d = data_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (consume) begin
            full_d = 1'b0;
            if (id_q) cnt1_d = cnt1_q + 16'd1;
            else      cnt0_d = cnt0_q + 16'd1;
        end
        // A new transfer overrides the drain so the slot stays full.
        if (xfer) begin
            full_d = 1'b1;
            last_d = gnt_id;
            id_d   = gnt_id;
            data_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            last_q <= 1'b1;
            id_q   <= 1'b0;
            data_q <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
            id_q   <= id_d;
            data_q <= data_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign rsp_valid = full_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy_cnt0 = cnt0_q;
    assign busy_cnt1 = cnt1_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, such as the main datapath issue slot and a secondary sequencer. Round-robin arbitration, valid/ready handshakes on both request ports and on the single response port. The result is registered, and one result is held until the consumer takes it. Sits between the requesters and the per-bit gate-level logic operators of the ALU.

## Interface
- WIDTH, 32, operand and result width in bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds an unconsumed result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  registered result.
- busy_cnt0, busy_cnt1  out  16  completed-operation counters, one per requester.

## Operation
- Internal state: `full` (drives rsp_valid), `last_grant` (1 bit), the result/id registers and the two counters.
- Issue slot is free when `!full || rsp_ready`. This allows back-to-back issue while the consumer drains.
- Grant selection is combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = slot free AND grant==N AND rst_n high. At most one ready is high per cycle. Ready never depends on the non-granted requester's ready.
- A transfer occurs on reqN_valid && reqN_ready. On the next edge:
  - rsp_data <= op(reqN_a, reqN_b)
  - rsp_id <= N
  - full <= 1
  - last_grant <= N
- Result operation is per-bit: a&b, a|b, a^b, ~(a|b). No carries, no sign handling.
- Consumption: rsp_valid && rsp_ready with no new transfer -> full <= 0. rsp_data and rsp_id hold their last values.
- Simultaneous consume and transfer: the new result replaces the old one in the same edge, and full stays 1.
- Stall: while full && !rsp_ready, rsp_data, rsp_id and rsp_valid are stable, and both readies are 0.
- last_grant changes only on a transfer. An idle cycle does not rotate priority.
- busy_cntN increments on each consumption of a result with rsp_id==N. It wraps 0xFFFF -> 0x0000.
- Requesters must hold valid and operands stable until ready. The block does not check this.

## Timing
- Reset (rst_n low, async) clears: rsp_valid=0, rsp_data=0, rsp_id=0, busy_cnt0=busy_cnt1=0, req0_ready=req1_ready=0. last_grant resets to 1, so requester 0 wins the first contention.
- Reset asserted mid-operation discards any held result and does not report it. The first cycle after rst_n rises may accept a request.
- Latency: transfer at edge k -> rsp_valid=1 and rsp_data valid after edge k.
- Throughput: one operation per cycle while rsp_ready stays high. Alternates 0,1,0,1 under continuous contention.
- Worst-case wait for a valid requester is 2 transfers after it raises valid, given the consumer keeps draining.
- Counter update occurs on the same edge as consumption.

## Test plan
- Reset, then req0 only: valid, op=01, a=0x0000_00F0, b=0x0000_000F, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=0x0000_00FF, rsp_id=0. busy_cnt0=1 after the consume edge.
- All ops on req1 with a=0xFFFF_0000, b=0x0F0F_0F0F:
  - AND -> 0x0F0F_0000
  - OR -> 0xFFFF_0F0F
  - XOR -> 0xF0F0_0F0F
  - NOR -> 0x0000_F0F0
- Both valid continuously, rsp_ready=1 for 6 cycles -> rsp_id sequence 0,1,0,1,0,1 with one result per cycle. busy_cnt0=busy_cnt1=3.
- Stall: result held, rsp_ready=0 for 4 cycles with req0 and req1 valid -> both readies 0, rsp_data/rsp_id unchanged. rsp_ready=1 -> consume and new transfer on the same edge, with rsp_valid staying 1.
- Reset pulse while full with rsp_ready=0 -> rsp_valid drops immediately (async), counters=0. After release, contention grants req0 first.
- Counter wrap: 65536 consumed req0 results -> busy_cnt0 returns to 0x0000, and busy_cnt1 is unaffected.
